// File: rtl/cnn_pkg.sv
// cnn_pkg: image geometry constants and controller state
// encoding shared by the binary input-image sequencer.
package cnn_pkg;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 3;
    localparam int ADDR_W = 10;
    localparam int PIX    = IMG_W * IMG_H;
    localparam int NWIN   = (IMG_H - K + 1) * (IMG_W - K + 1);

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        SER     = 3'd1,
        SCAN_RD = 3'd2,
        CAP     = 3'd3,
        OUT     = 3'd4,
        DONE    = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/cnn_window_addr_gen.sv
// cnn_window_addr_gen: walks the r/c window origin and the
// k kernel index, and forms the RAM read address for each tap.
// Ports: clk, rst_n; rd_en (one tap per cycle), win_adv (window
// accepted); k / rd_last (tap index, last tap); last_win
// (origin is the final window); ram_addr_rd (held when idle).
module cnn_window_addr_gen #(
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int K      = cnn_pkg::K,
    parameter int ADDR_W = cnn_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic              win_adv,
    output logic [3:0]        k,
    output logic              rd_last,
    output logic              last_win,
    output logic [ADDR_W-1:0] ram_addr_rd
);
    import cnn_pkg::*;

    logic [4:0]        r;
    logic [4:0]        c;
    logic [1:0]        j;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] koff;
    logic [ADDR_W-1:0] addr_now;
    logic [ADDR_W-1:0] addr_q;

    // row_base = r*IMG_W and koff = i*IMG_W are kept as
    // running sums so the address needs adders only.
    assign addr_now = row_base + koff
                    + ADDR_W'(c) + ADDR_W'(j);

    assign ram_addr_rd = rd_en ? addr_now : addr_q;
    assign rd_last     = (k == 4'(K * K - 1));
    assign last_win    = (r == 5'(IMG_H - K))
                      && (c == 5'(IMG_W - K));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r        <= '0;
            c        <= '0;
            j        <= '0;
            k        <= '0;
            row_base <= '0;
            koff     <= '0;
            addr_q   <= '0;
        end else begin
            if (rd_en) begin
                addr_q <= addr_now;
                if (rd_last) begin
                    k    <= '0;
                    j    <= '0;
                    koff <= '0;
                end else begin
                    k <= k + 4'd1;
                    if (j == 2'(K - 1)) begin
                        j    <= '0;
                        koff <= koff + ADDR_W'(IMG_W);
                    end else begin
                        j <= j + 2'd1;
                    end
                end
            end
            if (win_adv) begin
                if (c == 5'(IMG_W - K)) begin
                    c <= '0;
                    if (r == 5'(IMG_H - K)) begin
                        r        <= '0;
                        row_base <= '0;
                    end else begin
                        r        <= r + 5'd1;
                        row_base <= row_base + ADDR_W'(IMG_W);
                    end
                end else begin
                    c <= c + 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/cnn_input_ctrl.sv
// cnn_input_ctrl: loads packed pixel bytes into the binary image
// RAM, then streams every 3x3 window to the first conv layer.
// Ports: byte_valid/byte_data/byte_ready (packed input bytes),
// ram_wr/ram_din/ram_addr_wr (write side), ram_addr_rd/ram_dout
// (read side, 1-cycle latency), win_valid/win/win_ready (window
// stream), frame_done (pulse after last window accepted).
module cnn_input_ctrl #(
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int K      = cnn_pkg::K,
    parameter int ADDR_W = cnn_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              ram_wr,
    output logic              ram_din,
    output logic [ADDR_W-1:0] ram_addr_wr,
    output logic [ADDR_W-1:0] ram_addr_rd,
    input  logic              ram_dout,
    output logic              win_valid,
    output logic [8:0]        win,
    input  logic              win_ready,
    output logic              frame_done
);
    import cnn_pkg::*;

    localparam int NPIX = IMG_W * IMG_H;

    ctrl_state_t       state;
    logic [7:0]        byte_q;
    logic [2:0]        bit_q;
    logic [ADDR_W-1:0] wptr;
    logic [3:0]        k;
    logic              rd_en;
    logic              rd_last;
    logic              last_win;
    logic              accept;

    assign byte_ready  = (state == LOAD);
    assign ram_wr      = (state == SER);
    assign ram_din     = (state == SER) && byte_q[bit_q];
    assign ram_addr_wr = wptr;
    assign frame_done  = (state == DONE);
    assign rd_en       = (state == SCAN_RD);
    assign accept      = win_valid && win_ready;

    cnn_window_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_en       (rd_en),
        .win_adv     (accept),
        .k           (k),
        .rd_last     (rd_last),
        .last_win    (last_win),
        .ram_addr_rd (ram_addr_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            byte_q    <= '0;
            bit_q     <= '0;
            wptr      <= '0;
            win       <= '0;
            win_valid <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (byte_valid) begin
                        byte_q <= byte_data;
                        bit_q  <= '0;
                        state  <= SER;
                    end
                end
                SER: begin
                    wptr  <= wptr + ADDR_W'(1);
                    bit_q <= bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (wptr == ADDR_W'(NPIX - 1)) begin
                            wptr  <= '0;
                            state <= SCAN_RD;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                SCAN_RD: begin
                    // ram_dout now carries the tap issued last cycle
                    if (k != 4'd0) begin
                        win[k - 4'd1] <= ram_dout;
                    end
                    if (rd_last) begin
                        state <= CAP;
                    end
                end
                CAP: begin
                    win[8]    <= ram_dout;
                    win_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        state     <= last_win ? DONE : SCAN_RD;
                    end
                end
                DONE: begin
                    state <= LOAD;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule
